// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller signal bundle: ID-stage operand info, EX redirect and bus
// wait in; pipeline hold/flush, forwarding selects and debug counters out.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       id_rd;
  logic             id_rf_we;
  logic             id_is_load;
  logic             ex_redirect;
  logic             bus_busy;
  logic             pc_hold;
  logic             if_id_hold;
  logic             if_id_flush;
  logic             id_ex_hold;
  logic             id_ex_flush;
  logic             ex_mem_hold;
  logic             mem_wb_hold;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             bus_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_rf_we, id_is_load, ex_redirect, bus_busy,
    input  pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush,
           ex_mem_hold, mem_wb_hold, fwd_a_sel, fwd_b_sel, bus_err,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_rf_we, id_is_load, ex_redirect, bus_busy,
    output pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush,
           ex_mem_hold, mem_wb_hold, fwd_a_sel, fwd_b_sel, bus_err,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage RV32I pipeline: EX/MEM/WB write
// scoreboard, ID operand forwarding, load-use stall, redirect flush, bus freeze.
module pipe_hazard_ctrl #(
  parameter int unsigned BUS_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  pipe_hazard_ctrl_if.slave hz
);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_BUS_WAIT = 1'b1;
  localparam int unsigned TW = $clog2(BUS_TIMEOUT + 1);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       load;
  } sb_ent_t;

  sb_ent_t          sb_ex_q, sb_ex_d, sb_mem_q, sb_mem_d, sb_wb_q, sb_wb_d;
  logic [0:0]       state_q, state_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;

  logic       ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;
  logic       load_use, freeze, redirect, stall_lu;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic hit(sb_ent_t e, logic [4:0] rs, logic used, logic idv);
    return e.valid && e.we && (e.rd == rs) && (rs != 5'd0) && used && idv;
  endfunction

  // A loaded value is not ready in EX, so an EX load hit falls through to older stages.
  function automatic logic [1:0] sel(logic ex, logic ex_ld, logic mem, logic wb);
    if (ex && !ex_ld) return 2'b01;
    else if (mem)     return 2'b10;
    else if (wb)      return 2'b11;
    else              return 2'b00;
  endfunction

  always_comb begin
    ex_a     = hit(sb_ex_q,  hz.id_rs1, hz.id_rs1_used, hz.id_valid);
    ex_b     = hit(sb_ex_q,  hz.id_rs2, hz.id_rs2_used, hz.id_valid);
    mem_a    = hit(sb_mem_q, hz.id_rs1, hz.id_rs1_used, hz.id_valid);
    mem_b    = hit(sb_mem_q, hz.id_rs2, hz.id_rs2_used, hz.id_valid);
    wb_a     = hit(sb_wb_q,  hz.id_rs1, hz.id_rs1_used, hz.id_valid);
    wb_b     = hit(sb_wb_q,  hz.id_rs2, hz.id_rs2_used, hz.id_valid);
    fwd_a    = sel(ex_a, sb_ex_q.load, mem_a, wb_a);
    fwd_b    = sel(ex_b, sb_ex_q.load, mem_b, wb_b);
    load_use = (ex_a || ex_b) && sb_ex_q.load;
    freeze   = hz.bus_busy;
    redirect = hz.ex_redirect && !freeze;
    stall_lu = load_use && !freeze && !hz.ex_redirect;
  end

  // Combinational controls are forced quiet while reset is asserted.
  assign hz.pc_hold     = rst_i & (freeze | stall_lu);
  assign hz.if_id_hold  = rst_i & (freeze | stall_lu);
  assign hz.if_id_flush = rst_i & redirect;
  assign hz.id_ex_hold  = rst_i & freeze;
  assign hz.id_ex_flush = rst_i & (redirect | stall_lu);
  assign hz.ex_mem_hold = rst_i & freeze;
  assign hz.mem_wb_hold = rst_i & freeze;
  assign hz.fwd_a_sel   = rst_i ? fwd_a : 2'b00;
  assign hz.fwd_b_sel   = rst_i ? fwd_b : 2'b00;
  assign hz.bus_err     = bus_err_q;
  assign hz.stall_cnt   = stall_q;
  assign hz.flush_cnt   = flush_q;

  always_comb begin
    sb_ex_d   = sb_ex_q;
    sb_mem_d  = sb_mem_q;
    sb_wb_d   = sb_wb_q;
    state_d   = state_q;
    tmo_d     = tmo_q;
    bus_err_d = bus_err_q;
    stall_d   = stall_q;
    flush_d   = flush_q;

    if (freeze) begin
      state_d = ST_BUS_WAIT;
      if (state_q == ST_RUN) begin
        tmo_d = TW'(1);
      end else begin
        if (tmo_q == TW'(BUS_TIMEOUT - 1)) bus_err_d = 1'b1;
        if (tmo_q != '1) tmo_d = tmo_q + TW'(1);
      end
      if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
    end else begin
      state_d  = ST_RUN;
      tmo_d    = '0;
      sb_wb_d  = sb_mem_q;
      sb_mem_d = sb_ex_q;
      if (redirect || stall_lu) begin
        sb_ex_d = '0;
      end else begin
        sb_ex_d = '{valid: hz.id_valid, rd: hz.id_rd, we: hz.id_rf_we, load: hz.id_is_load};
      end
      if (redirect && flush_q != '1) flush_d = flush_q + CNT_W'(1);
      if (stall_lu && stall_q != '1) stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sb_ex_q   <= '0;
      sb_mem_q  <= '0;
      sb_wb_q   <= '0;
      state_q   <= ST_RUN;
      tmo_q     <= '0;
      bus_err_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      sb_ex_q   <= sb_ex_d;
      sb_mem_q  <= sb_mem_d;
      sb_wb_q   <= sb_wb_d;
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      bus_err_q <= bus_err_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

endmodule
